// File: rtl/clk_fwd_monitor_if.sv
// Readback/status bundle for clk_fwd_monitor: forwarded lines in, per-channel health out.
interface clk_fwd_monitor_if #(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 11
);
    logic [N_CH-1:0]  fwd_in;
    logic             clr_sticky;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             win_done;
    logic [N_CH-1:0]  ok;
    logic [N_CH-1:0]  fail;

    modport master (
        output fwd_in, clr_sticky, rd_sel,
        input  rd_data, win_done, ok, fail
    );

    modport slave (
        input  fwd_in, clr_sticky, rd_sel,
        output rd_data, win_done, ok, fail
    );
endinterface

// File: rtl/clk_fwd_monitor.sv
// Forwarded-clock health monitor: synchronises N_CH lines, counts rising edges per
// fixed window, and flags each channel as locked (ok) or out of range (sticky fail).
module clk_fwd_monitor #(
    parameter int unsigned N_CH         = 16,
    parameter int unsigned SEL_W        = 4,
    parameter int unsigned WINDOW       = 1024,
    parameter int unsigned CNT_W        = 11,
    parameter int unsigned MIN_EDGES    = 60,
    parameter int unsigned MAX_EDGES    = 68,
    parameter int unsigned LOCK_WINDOWS = 2
) (
    input  logic             clk,
    input  logic             rst,
    clk_fwd_monitor_if.slave bus
);
    localparam int unsigned       WIN_W     = $clog2(WINDOW);
    localparam int unsigned       GOOD_W    = $clog2(LOCK_WINDOWS + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_EDGES);

    logic [N_CH-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
    logic [N_CH-1:0]   edge_pulse;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic              terminal;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [CNT_W-1:0]  latched_q [N_CH];
    logic [CNT_W-1:0]  latched_d [N_CH];
    logic [CNT_W-1:0]  sat_cnt [N_CH];
    logic [GOOD_W-1:0] good_q [N_CH];
    logic [GOOD_W-1:0] good_d [N_CH];
    logic [N_CH-1:0]   in_range;
    logic [N_CH-1:0]   ok_q, ok_d, fail_q, fail_d;
    logic              win_done_q, win_done_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;

    always_comb begin
        sync1_d    = bus.fwd_in;
        sync2_d    = sync1_q;
        dly_d      = sync2_q;
        edge_pulse = sync2_q & ~dly_q;
        terminal   = (win_cnt_q == WIN_LAST);
        win_cnt_d  = terminal ? '0 : win_cnt_q + WIN_W'(1);
        win_done_d = terminal;
        // Clear first, then OR in this window's failures so a coincident bad window wins.
        fail_d     = bus.clr_sticky ? '0 : fail_q;
        in_range   = '0;
        ok_d       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sat_cnt[i]   = (edge_pulse[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
            in_range[i]  = (sat_cnt[i] >= MIN_CNT) && (sat_cnt[i] <= MAX_CNT);
            cnt_d[i]     = sat_cnt[i];
            latched_d[i] = latched_q[i];
            good_d[i]    = good_q[i];
            if (terminal) begin
                cnt_d[i]     = '0;
                latched_d[i] = sat_cnt[i];
                if (in_range[i]) begin
                    good_d[i] = (good_q[i] == GOOD_LOCK) ? good_q[i] : good_q[i] + GOOD_W'(1);
                end else begin
                    good_d[i] = '0;
                    fail_d[i] = 1'b1;
                end
            end
            ok_d[i] = (good_d[i] == GOOD_LOCK);
        end
        rd_data_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_data_d = latched_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            dly_q      <= '0;
            win_cnt_q  <= '0;
            win_done_q <= 1'b0;
            ok_q       <= '0;
            fail_q     <= '0;
            rd_data_q  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i]     <= '0;
                latched_q[i] <= '0;
                good_q[i]    <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            dly_q      <= dly_d;
            win_cnt_q  <= win_cnt_d;
            win_done_q <= win_done_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
            rd_data_q  <= rd_data_d;
            cnt_q      <= cnt_d;
            latched_q  <= latched_d;
            good_q     <= good_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.win_done = win_done_q;
    assign bus.ok       = ok_q;
    assign bus.fail     = fail_q;
endmodule
